// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: emulates a variable-reluctance crank sensor (N-M toothed wheel).
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module crank_wheel_gen #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [W-1:0] period_in,
    input  logic         period_we,
    input  logic [7:0]   teeth_total,
    input  logic [7:0]   teeth_missing,
    output logic         vr_out,
    output logic         gap_flag,
    output logic         rev_pulse,
    output logic [7:0]   slot_idx,
    output logic         cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic [W-1:0] pa, pa_nxt;
    logic [W-1:0] shadow, shadow_nxt;
    logic [7:0]   n_lat, n_nxt;
    logic [7:0]   m_lat, m_nxt;
    logic [7:0]   slot_nxt;
    logic         cfg_err_nxt;
    logic         rev_nxt;
    logic         vr_nxt;
    logic         gap_nxt;

    logic [W-1:0] shadow_eff;
    logic [W-1:0] pa_start;
    logic         cfg_legal;
    logic         last_cyc;
    logic         start;
    logic [7:0]   slot_inc;

    // A period strobe coinciding with a revolution start bypasses the shadow.
    always_comb begin
        shadow_eff = period_we ? period_in : shadow;
        pa_start   = (shadow_eff < W'(2)) ? W'(2) : shadow_eff;
        cfg_legal  = (teeth_total >= 8'd3) &&
                     (({1'b0, teeth_missing} + 9'd2) <= {1'b0, teeth_total});
        last_cyc   = (cnt == (pa - W'(1)));
        slot_inc   = slot_idx + 8'd1;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        slot_nxt    = slot_idx;
        pa_nxt      = pa;
        n_nxt       = n_lat;
        m_nxt       = m_lat;
        shadow_nxt  = shadow_eff;
        cfg_err_nxt = cfg_err;
        rev_nxt     = 1'b0;
        start       = 1'b0;

        case (state)
            IDLE: begin
                if (ena) begin
                    start = 1'b1;
                end
            end
            default: begin
                if (!ena) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    slot_nxt  = 8'd0;
                end else if (last_cyc) begin
                    if (slot_idx == (n_lat - 8'd1)) begin
                        start = 1'b1;
                    end else begin
                        slot_nxt  = slot_inc;
                        cnt_nxt   = '0;
                        state_nxt = (slot_inc >= (n_lat - m_lat)) ? GAP : HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + W'(1);
                    if ((state == HIGH) && ((cnt + W'(1)) == (pa >> 1))) begin
                        state_nxt = LOW;
                    end
                end
            end
        endcase

        // Revolution start: relatch geometry and period, then run or refuse.
        if (start) begin
            pa_nxt   = pa_start;
            n_nxt    = teeth_total;
            m_nxt    = teeth_missing;
            cnt_nxt  = '0;
            slot_nxt = 8'd0;
            if (cfg_legal) begin
                state_nxt   = HIGH;
                rev_nxt     = 1'b1;
                cfg_err_nxt = 1'b0;
            end else begin
                state_nxt   = IDLE;
                cfg_err_nxt = 1'b1;
            end
        end

        vr_nxt  = (state_nxt == HIGH);
        gap_nxt = (state_nxt == GAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pa        <= W'(2);
            shadow    <= W'(2);
            n_lat     <= 8'd0;
            m_lat     <= 8'd0;
            slot_idx  <= 8'd0;
            cfg_err   <= 1'b0;
            rev_pulse <= 1'b0;
            vr_out    <= 1'b0;
            gap_flag  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pa        <= pa_nxt;
            shadow    <= shadow_nxt;
            n_lat     <= n_nxt;
            m_lat     <= m_nxt;
            slot_idx  <= slot_nxt;
            cfg_err   <= cfg_err_nxt;
            rev_pulse <= rev_nxt;
            vr_out    <= vr_nxt;
            gap_flag  <= gap_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_crank_wheel_gen.sv
// tb_crank_wheel_gen: scoreboard bench for crank_wheel_gen; expected waveforms built per slot.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module tb_crank_wheel_gen;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic [W-1:0] period_in;
    logic         period_we;
    logic [7:0]   teeth_total;
    logic [7:0]   teeth_missing;
    logic         vr_out;
    logic         gap_flag;
    logic         rev_pulse;
    logic [7:0]   slot_idx;
    logic         cfg_err;

    typedef struct packed {
        logic       vr;
        logic       gap;
        logic       rev;
        logic [7:0] slot;
        logic       cfg;
    } exp_t;

    exp_t  sb[$];
    string nq[$];
    int    checks = 0;
    int    errors = 0;
    event  chk_now;

    localparam exp_t ZERO     = '{vr: 1'b0, gap: 1'b0, rev: 1'b0, slot: 8'd0, cfg: 1'b0};
    localparam exp_t ZERO_ERR = '{vr: 1'b0, gap: 1'b0, rev: 1'b0, slot: 8'd0, cfg: 1'b1};

    crank_wheel_gen #(.W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .period_in     (period_in),
        .period_we     (period_we),
        .teeth_total   (teeth_total),
        .teeth_missing (teeth_missing),
        .vr_out        (vr_out),
        .gap_flag      (gap_flag),
        .rev_pulse     (rev_pulse),
        .slot_idx      (slot_idx),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    // Monitor: drains the scoreboard on each falling edge or on demand.
    initial begin
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(negedge clk or chk_now);
            while (sb.size() > 0) begin
                e  = sb.pop_front();
                nm = nq.pop_front();
                a  = '{vr: vr_out, gap: gap_flag, rev: rev_pulse, slot: slot_idx, cfg: cfg_err};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s t=%0t: got vr=%0b gap=%0b rev=%0b slot=%0d cfg=%0b, expected vr=%0b gap=%0b rev=%0b slot=%0d cfg=%0b",
                             nm, $time, a.vr, a.gap, a.rev, a.slot, a.cfg,
                             e.vr, e.gap, e.rev, e.slot, e.cfg);
                end
            end
        end
    end

    task automatic cyc(input exp_t e, input string nm);
        @(posedge clk);
        #1;
        sb.push_back(e);
        nq.push_back(nm);
    endtask

    // One revolution of expected output for active period p, n slots, m missing.
    // Optional hooks fire after output index: period strobe, geometry change, early stop.
    task automatic rev_wave(input int p, input int n, input int m, input int stop,
                            input int we_after, input int we_val,
                            input int cfg_after, input int nn, input int nm_,
                            input string tag);
        int   idx  = 0;
        int   half = p / 2;
        exp_t e;
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < p; c++) begin
                if (stop >= 0 && idx >= stop) return;
                e.vr   = (s < n - m) && (c < half);
                e.gap  = (s >= n - m);
                e.rev  = (s == 0) && (c == 0);
                e.slot = 8'(s);
                e.cfg  = 1'b0;
                cyc(e, tag);
                period_we = 1'b0;
                if (idx == we_after) begin
                    period_in = W'(we_val);
                    period_we = 1'b1;
                end
                if (idx == cfg_after) begin
                    teeth_total   = 8'(nn);
                    teeth_missing = 8'(nm_);
                end
                idx++;
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        ena           = 1'b0;
        period_in     = '0;
        period_we     = 1'b0;
        teeth_total   = 8'd0;
        teeth_missing = 8'd0;

        cyc(ZERO, "reset");
        cyc(ZERO, "reset_hold");

        rst           = 1'b0;
        ena           = 1'b1;
        period_in     = W'(10);
        period_we     = 1'b1;
        teeth_total   = 8'd60;
        teeth_missing = 8'd2;

        rev_wave(10, 60, 2, -1, -1, 0, -1, 0, 0, "nominal");
        rev_wave(10, 60, 2, -1, 300, 20, -1, 0, 0, "mid_period_chg");
        rev_wave(20, 60, 2, -1, 1199, 7, -1, 0, 0, "period20");
        rev_wave(7, 60, 2, -1, 419, 1, 10, 6, 1, "period7");
        rev_wave(2, 6, 1, -1, 11, 10, 3, 60, 2, "clamp_p1");

        rev_wave(10, 60, 2, 123, -1, 0, -1, 0, 0, "ena_drop_run");
        ena = 1'b0;
        cyc(ZERO, "ena_drop");
        cyc(ZERO, "idle_hold");
        ena = 1'b1;
        rev_wave(10, 60, 2, -1, -1, 0, -1, 0, 0, "restart");
        ena = 1'b0;
        cyc(ZERO, "stop_at_rev_end");

        teeth_total   = 8'd2;
        teeth_missing = 8'd0;
        ena           = 1'b1;
        cyc(ZERO_ERR, "illegal_n2");
        cyc(ZERO_ERR, "illegal_n2_hold");
        teeth_total   = 8'd10;
        teeth_missing = 8'd9;
        cyc(ZERO_ERR, "illegal_m9");
        teeth_missing = 8'd8;
        rev_wave(10, 10, 8, -1, -1, 0, 50, 2, 0, "legal_m8");
        cyc(ZERO_ERR, "illegal_relatch");

        teeth_total   = 8'd6;
        teeth_missing = 8'd2;
        rev_wave(10, 6, 2, 43, -1, 0, -1, 0, 0, "pre_async_rst");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        sb.push_back(ZERO);
        nq.push_back("async_rst");
        -> chk_now;
        #1;
        rst = 1'b0;
        rev_wave(2, 6, 2, -1, -1, 0, -1, 0, 0, "post_rst");
        ena = 1'b0;
        cyc(ZERO, "final_stop");

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout at t=%0t, expected completion", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
